ir_frame_packer: RTL

IR_FRAME_PACKER -- requirements
Module: ir_frame_packer

---
 rtl/ir_frame_packer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ir_frame_packer.sv
// ir_frame_packer: gathers payload bytes from a byte stream and emits framed
// packets (SYNC0, SYNC1, ADDR hi, ADDR lo, LEN, payload) one byte at a time to a
// UART transmitter using a valid/done handshake. A partial payload is flushed
// as a short frame after TIMEOUT_CYC idle cycles (0 disables the flush).
// Optional macro IR_FRAME_CHECKSUM_EN appends CHK = LEN ^ payload bytes.
module ir_frame_packer #(
  parameter int          PAYLOAD_LEN = 4,
  parameter logic [7:0]  SYNC0       = 8'hFA,
  parameter logic [7:0]  SYNC1       = 8'hF1,
  parameter logic [15:0] ADDR        = 16'h0001,
  parameter int          TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       frame_done
);

`ifdef IR_FRAME_CHECKSUM_EN
  localparam logic [4:0] CHK_BYTES = 5'd1;
`else
  localparam logic [4:0] CHK_BYTES = 5'd0;
`endif

  // Idle counter only needs to reach TIMEOUT_CYC-1.
  localparam int          TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [3:0]  PLEN    = 4'(PAYLOAD_LEN);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LOAD, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [3:0]      len_q, len_d;
  logic [4:0]      idx_q, idx_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      xor_q, xor_d;

  logic [7:0]      buf_q [0:15];
  logic            buf_we;
  logic [3:0]      buf_waddr;

  logic            accept;
  logic [4:0]      last_idx;
  logic [4:0]      nxt_idx;
  logic [4:0]      pidx_full;
  logic [7:0]      sel_byte;

  assign accept   = in_valid & in_ready;
  // Index of the final byte in the current frame (header is 5 bytes).
  assign last_idx = 5'd4 + {1'b0, len_q} + CHK_BYTES;

  // Select the frame byte that follows the one currently on the wire.
  always_comb begin
    nxt_idx   = idx_q + 5'd1;
    pidx_full = nxt_idx - 5'd5;
    sel_byte  = 8'h00;
    case (nxt_idx)
      5'd0: sel_byte = SYNC0;
      5'd1: sel_byte = SYNC1;
      5'd2: sel_byte = ADDR[15:8];
      5'd3: sel_byte = ADDR[7:0];
      5'd4: sel_byte = {4'h0, len_q};
      default: begin
        if (pidx_full < {1'b0, len_q}) begin
          sel_byte = buf_q[pidx_full[3:0]];
        end else begin
          sel_byte = {4'h0, len_q} ^ xor_q;
        end
      end
    endcase
  end

  // Next-state and output decode for the collect/transmit FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    idx_d      = idx_q;
    idle_d     = idle_q;
    tx_data_d  = tx_data_q;
    xor_d      = xor_q;
    buf_we     = 1'b0;
    buf_waddr  = count_q;
    frame_done = 1'b0;
    in_ready   = (state_q == S_IDLE) || (state_q == S_COLLECT);
    tx_valid   = (state_q == S_LOAD);
    busy       = (state_q == S_LOAD) || (state_q == S_WAIT);
    tx_data    = tx_data_q;

    case (state_q)
      S_IDLE: begin
        idx_d = 5'd0;
        if (accept) begin
          buf_we    = 1'b1;
          buf_waddr = 4'd0;
          count_d   = 4'd1;
          xor_d     = in_data;
          idle_d    = '0;
          if (PLEN == 4'd1) begin
            state_d   = S_LOAD;
            len_d     = 4'd1;
            tx_data_d = SYNC0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          buf_we    = 1'b1;
          buf_waddr = count_q;
          count_d   = count_q + 4'd1;
          xor_d     = xor_q ^ in_data;
          idle_d    = '0;
          if (count_q + 4'd1 == PLEN) begin
            state_d   = S_LOAD;
            len_d     = PLEN;
            idx_d     = 5'd0;
            tx_data_d = SYNC0;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (idle_q == TO_LAST) begin
            // Flush the partial payload as a short frame.
            state_d   = S_LOAD;
            len_d     = count_q;
            idx_d     = 5'd0;
            idle_d    = '0;
            tx_data_d = SYNC0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (idx_q == last_idx) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
            count_d    = 4'd0;
            idx_d      = 5'd0;
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = sel_byte;
            state_d   = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd0;
      len_q     <= 4'd0;
      idx_q     <= 5'd0;
      idle_q    <= '0;
      tx_data_q <= 8'h00;
      xor_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      tx_data_q <= tx_data_d;
      xor_q     <= xor_d;
    end
  end

  // Payload buffer; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= in_data;
    end
  end

endmodule
